// File: rtl/wb_dffram_port.sv
// -----------------------------------------------------------------------------
// wb_dffram_port
//
// Wishbone classic (B4, non-pipelined) slave in front of a single-port 32-bit
// DFFRAM macro. Each accepted bus transfer becomes one RAM strobe. The RAM
// returns registered read data for one cycle only and zeroes its output on
// every disabled cycle, so this block captures that word as soon as it appears.
// Accesses outside the address window are answered with an error and never
// reach the RAM.
//
// Parameters
//   A_WIDTH   RAM word-address width (RAM holds 2**A_WIDTH words)
//   BASE      byte base address of the window; bits [A_WIDTH+1:0] ignored
//
// Ports
//   CLK        sole clock, shared with the RAM
//   RST        synchronous active-high reset
//   wb_cyc_i   bus cycle valid
//   wb_stb_i   transfer strobe
//   wb_we_i    1 = write, 0 = read
//   wb_sel_i   byte lane enables (bit n -> bits [8n+7:8n])
//   wb_adr_i   byte address
//   wb_dat_i   write data
//   wb_dat_o   registered read data, held until the next read completes
//   wb_ack_o   registered one-cycle acknowledge
//   wb_err_o   registered one-cycle error for out-of-window accesses
//   ram_en     RAM EN0
//   ram_we     RAM WE0 (per byte lane)
//   ram_a      RAM A0, word address taken straight from wb_adr_i
//   ram_di     RAM Di0, straight from wb_dat_i
//   ram_do     RAM Do0, valid the cycle after an enabled edge, else 0
// -----------------------------------------------------------------------------
module wb_dffram_port #(
   parameter int unsigned A_WIDTH = 9,
   parameter logic [31:0] BASE    = 32'h0000_0000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   input  logic [3:0]         wb_sel_i,
   input  logic [31:0]        wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   output logic [31:0]        wb_dat_o,
   output logic               wb_ack_o,
   output logic               wb_err_o,
   output logic               ram_en,
   output logic [3:0]         ram_we,
   output logic [A_WIDTH-1:0] ram_a,
   output logic [31:0]        ram_di,
   input  logic [31:0]        ram_do
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_dat;

   logic        w_req;
   logic        w_hit;
   logic        w_en;
   logic        w_ack_nxt;
   logic        w_err_nxt;
   logic        w_unused;

   assign w_req = wb_cyc_i & wb_stb_i;
   assign w_hit = (wb_adr_i[31:A_WIDTH+2] == BASE[31:A_WIDTH+2]);

   // Byte offset bits carry no meaning: every access is a full aligned word.
   assign w_unused = &{1'b0, wb_adr_i[1:0]};

   // Next-state and RAM strobe decode. The strobe is only ever raised in IDLE,
   // so the RAM sees exactly one enabled edge per accepted in-window request.
   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_en        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  // Gate with RST so a write coinciding with reset never lands.
                  w_en = ~RST;
                  if (wb_we_i) begin
                     w_state_nxt = S_RESP;
                     w_ack_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = S_RD;
                  end
               end else begin
                  w_state_nxt = S_RESP;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         S_RD: begin
            // Dropping CYC here abandons the transfer without an ack.
            if (wb_cyc_i) begin
               w_state_nxt = S_RESP;
               w_ack_nxt   = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         // RAM output is only valid during RD; capture it before it clears,
         // even if the master has aborted the cycle.
         if (r_state == S_RD) begin
            r_dat <= ram_do;
         end
      end
   end

   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;

   assign ram_en = w_en;
   assign ram_we = (w_en && wb_we_i) ? wb_sel_i : 4'b0000;
   assign ram_a  = wb_adr_i[A_WIDTH+1:2];
   assign ram_di = wb_dat_i;

endmodule

// File: tb/tb_wb_dffram_port.sv
// -----------------------------------------------------------------------------
// tb_wb_dffram_port
//
// Drives wb_dffram_port with directed and randomized Wishbone transfers. A
// behavioural DFFRAM stands in for the macro; an independent word-array model
// holds the expected memory contents and expected handshake counts.
// -----------------------------------------------------------------------------
module tb_wb_dffram_port;

   localparam int          A_W     = 6;
   localparam int          DEPTH   = 1 << A_W;
   localparam logic [31:0] BASE_TB = 32'h1000_0000;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           wb_cyc_i = 1'b0;
   logic           wb_stb_i = 1'b0;
   logic           wb_we_i  = 1'b0;
   logic [3:0]     wb_sel_i = 4'h0;
   logic [31:0]    wb_adr_i = 32'h0;
   logic [31:0]    wb_dat_i = 32'h0;
   logic [31:0]    wb_dat_o;
   logic           wb_ack_o;
   logic           wb_err_o;
   logic           ram_en;
   logic [3:0]     ram_we;
   logic [A_W-1:0] ram_a;
   logic [31:0]    ram_di;
   logic [31:0]    ram_do = 32'h0;

   wb_dffram_port #(.A_WIDTH(A_W), .BASE(BASE_TB)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_a    (ram_a),
      .ram_di   (ram_di),
      .ram_do   (ram_do)
   );

   always #5 CLK = ~CLK;

   // Behavioural DFFRAM: registered read, output zero on disabled cycles.
   logic [31:0] mem [DEPTH];
   always @(posedge CLK) begin
      if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
         ram_do <= mem[ram_a];
      end else begin
         ram_do <= 32'h0;
      end
   end

   // Reference model state.
   logic [31:0] exp_mem [DEPTH];
   int exp_acks = 0;
   int exp_errs = 0;
   int exp_ens  = 0;

   // Observed handshake totals.
   int n_ack  = 0;
   int n_err  = 0;
   int n_en   = 0;
   int n_both = 0;
   always @(negedge CLK) begin
      if (wb_ack_o === 1'b1) n_ack++;
      if (wb_err_o === 1'b1) n_err++;
      if (ram_en === 1'b1) n_en++;
      if (wb_ack_o === 1'b1 && wb_err_o === 1'b1) n_both++;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++)
         if (sel[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   function automatic bit in_window(input logic [31:0] adr);
      return (adr >> (A_W + 2)) == (BASE_TB >> (A_W + 2));
   endfunction

   // One transfer, started just after a rising edge. rel=0 keeps CYC/STB high
   // into the next call, giving back-to-back streaming.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit rel);
      bit          hit;
      int          idx;
      int          lat;
      int          exp_lat;
      logic [31:0] m;
      hit = in_window(adr);
      idx = (adr >> 2) % DEPTH;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      @(negedge CLK);
      chk("ram_en", {31'h0, ram_en}, {31'h0, hit});
      chk("ram_we", {28'h0, ram_we}, (hit && we) ? {28'h0, sel} : 32'h0);
      chk("ram_a", {26'h0, ram_a}, idx);
      chk("ram_di", ram_di, dat);
      lat = 0;
      while (!(wb_ack_o === 1'b1 || wb_err_o === 1'b1) && lat < 8) begin
         @(negedge CLK);
         lat++;
      end
      exp_lat = (hit && !we) ? 2 : 1;
      chk("latency", lat, exp_lat);
      chk("ack", {31'h0, wb_ack_o}, {31'h0, hit});
      chk("err", {31'h0, wb_err_o}, {31'h0, !hit});
      if (hit) begin
         exp_acks++;
         exp_ens++;
         if (we) begin
            m = lane_mask(sel);
            exp_mem[idx] = (exp_mem[idx] & ~m) | (dat & m);
         end else begin
            chk("rdata", wb_dat_o, exp_mem[idx]);
         end
      end else begin
         exp_errs++;
      end
      @(posedge CLK);
      #1;
      if (rel) begin
         wb_cyc_i = 1'b0;
         wb_stb_i = 1'b0;
      end
   endtask

   initial begin
      int          idx;
      logic [31:0] adr;
      bit          we;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'h0;
         exp_mem[i] = 32'h0;
      end

      // Reset held for two cycles.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("rst_err", {31'h0, wb_err_o}, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      chk("rst_en", {31'h0, ram_en}, 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Full-word write then read back.
      xfer(1'b1, BASE_TB + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
      xfer(1'b0, BASE_TB + 32'h10, 32'h0, 4'hF, 1'b1);
      chk("rd_deadbeef", wb_dat_o, 32'hDEAD_BEEF);

      // Byte-lane write.
      xfer(1'b1, BASE_TB + 32'h10, 32'h1122_3344, 4'b0101, 1'b1);
      xfer(1'b0, BASE_TB + 32'h10, 32'h0, 4'h0, 1'b1);
      chk("rd_lanes", wb_dat_o, 32'hDE22_BE44);

      // Out-of-window access, then in-window data unchanged.
      xfer(1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF, 1'b1);
      xfer(1'b0, BASE_TB + 32'h10, 32'h0, 4'hF, 1'b1);
      chk("rd_after_err", wb_dat_o, 32'hDE22_BE44);

      // Streaming: 4 writes then 4 reads with STB held high throughout.
      for (int i = 0; i < 4; i++)
         xfer(1'b1, BASE_TB + 32'h20 + 4 * i, 32'hA5A5_0000 + i, 4'hF, 1'b0);
      for (int i = 0; i < 4; i++)
         xfer(1'b0, BASE_TB + 32'h20 + 4 * i, 32'h0, 4'hF, i == 3);
      chk("stream_last", wb_dat_o, 32'hA5A5_0003);

      // Abort in RD: no ack, data still captured, FSM back in IDLE.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = BASE_TB + 32'h10; wb_sel_i = 4'hF;
      exp_ens++;
      @(posedge CLK);
      #1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge CLK);
      chk("abort_ack_rd", {31'h0, wb_ack_o}, 32'h0);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("abort_ack_nx", {31'h0, wb_ack_o}, 32'h0);
      chk("abort_dat", wb_dat_o, 32'hDE22_BE44);
      @(posedge CLK);
      #1;
      xfer(1'b0, BASE_TB + 32'h24, 32'h0, 4'hF, 1'b1);

      // Reset during RD: read dropped, data cleared.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = BASE_TB + 32'h10; wb_sel_i = 4'hF;
      exp_ens++;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rstrd_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("rstrd_dat", wb_dat_o, 32'h0);
      @(posedge CLK);
      #1;

      // Write issued while RST is high must not reach the RAM.
      RST = 1'b1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = BASE_TB + 32'h10; wb_dat_i = 32'h0BAD_0BAD; wb_sel_i = 4'hF;
      @(negedge CLK);
      chk("rstwr_en", {31'h0, ram_en}, 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(posedge CLK);
      #1;
      xfer(1'b0, BASE_TB + 32'h10, 32'h0, 4'hF, 1'b1);
      chk("rstwr_keep", wb_dat_o, 32'hDE22_BE44);

      // Randomized traffic against the model.
      for (int n = 0; n < 120; n++) begin
         we = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            adr = $urandom;
            if (in_window(adr)) adr = adr ^ 32'h8000_0000;
         end else begin
            adr = BASE_TB + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
         end
         xfer(we, adr, $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
         if (!wb_cyc_i && $urandom_range(0, 3) == 0) begin
            @(posedge CLK);
            #1;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);

      // Every word of RAM against the model.
      for (int i = 0; i < DEPTH; i++) begin
         idx = i;
         chk("mem_final", mem[idx], exp_mem[idx]);
      end

      chk("total_acks", n_ack, exp_acks);
      chk("total_errs", n_err, exp_errs);
      chk("total_en", n_en, exp_ens);
      chk("ack_and_err", n_both, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_dffram_port.md
# wb_dffram_port

Wishbone classic (B4, non-pipelined) slave that fronts one 32-bit DFFRAM macro (e.g. the 512x32 instance) and turns bus cycles into single-port RAM strobes. It sits directly upstream of the RAM and drives its CLK-domain EN/WE/A/Di pins. It captures the RAM's registered read data before it is cleared, because the RAM zeroes its output on any disabled cycle. It also decodes its own address window and returns an error outside it.

## Interface
- A_WIDTH, 9: RAM word-address width; the RAM holds 2**A_WIDTH words.
- BASE, 32'h0000_0000: byte base address of the window; bits [A_WIDTH+1:0] are ignored.

- CLK  in  1  sole clock; the RAM shares it.
- RST  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  transfer strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte lane enables; bit n selects bits [8n+7:8n].
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  registered read data.
- wb_ack_o  out  1  registered transfer acknowledge.
- wb_err_o  out  1  registered error; asserted for an out-of-window access.
- ram_en  out  1  to RAM EN0.
- ram_we  out  4  to RAM WE0.
- ram_a  out  A_WIDTH  to RAM A0; equals wb_adr_i[A_WIDTH+1:2].
- ram_di  out  32  to RAM Di0; equals wb_dat_i.
- ram_do  in  32  from RAM Do0; valid the cycle after an enabled edge, and 0 otherwise.

## Operation
- req = wb_cyc_i & wb_stb_i.
- hit = (wb_adr_i[31:A_WIDTH+2] == BASE[31:A_WIDTH+2]).
- FSM states:
  - IDLE: accepts requests.
  - RD: RAM read in flight.
  - RESP: ack/err cycle; no new access starts here.
- IDLE & req & hit & !RST:
  - ram_en=1, combinationally in the same cycle.
  - ram_we = wb_we_i ? wb_sel_i : 4'b0.
  - Read → RD. Write → RESP with wb_ack_o=1.
- IDLE & req & !hit:
  - ram_en stays 0; the RAM is not touched.
  - → RESP with wb_err_o=1.
- RD:
  - wb_dat_o <= ram_do at the edge.
  - If wb_cyc_i=1 → RESP with wb_ack_o=1.
  - If wb_cyc_i=0 (abort) → IDLE; no ack, wb_dat_o is still loaded.
- RESP: wb_ack_o and wb_err_o clear at the edge; → IDLE.
- ram_en=0 and ram_we=0 in RD and RESP, and in every state while RST=1.
- ram_a and ram_di are pure pass-through in all states.
- Write with wb_sel_i=4'b0: the RAM is enabled with WE=0, the RAM contents are unchanged, and the write is acked normally.
- Reads ignore wb_sel_i; the full word is always returned.
- wb_adr_i[1:0] are ignored; there is no misalignment error.
- wb_ack_o and wb_err_o are never asserted together.
- wb_ack_o and wb_err_o are high for exactly one cycle per accepted request.

## Timing
- The request is first seen in IDLE at cycle N.
- Write: RAM written at edge N→N+1. wb_ack_o high in cycle N+1. IDLE in N+2.
- Read:
  - RAM read at edge N→N+1; ram_do valid in N+1.
  - wb_dat_o loaded at edge N+1→N+2; wb_ack_o high in N+2.
  - IDLE in N+3.
- Error: wb_err_o high in N+1, IDLE in N+2.
- Back-to-back: if req is still high in the ack cycle, the next request is accepted in the following cycle (IDLE). Throughput is one write per 2 cycles and one read per 3 cycles.
- wb_dat_o holds its value until the next read completes; it is not cleared after ack.
- Reset (at any edge with RST=1):
  - state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - An in-flight read is dropped without ack.
  - An IDLE-cycle write coinciding with RST is not issued (ram_en gated by RST).
- Cycle drop in RESP has no effect; the FSM returns to IDLE regardless.

## Test plan
- Reset with RST=1 for 2 cycles → wb_ack_o=0, wb_err_o=0, wb_dat_o=0, ram_en=0; IDLE next cycle.
- Write to adr 0x10, data 0xDEADBEEF, sel=4'hF:
  - ack in N+1.
  - Then a read of 0x10 → ack in N+2 with wb_dat_o=0xDEADBEEF.
- Byte-lane write: sel=4'b0101, data 0x11223344 over 0xDEADBEEF at 0x10 → a subsequent read returns 0xDE22BE44.
- Out-of-window access:
  - With BASE=0x1000_0000, access adr 0x2000_0000 → wb_err_o in N+1, no ack, ram_en never high.
  - A following read of the in-window address returns the old data.
- Back-to-back streaming:
  - Stb held high for 4 writes to consecutive words, then 4 reads.
  - Acks spaced 2 cycles for writes and 3 for reads.
  - Data matches, no missed or duplicate acks.
- Abort and reset:
  - Drop wb_cyc_i in RD → no ack, IDLE next cycle.
  - Assert RST in RD → no ack, wb_dat_o=0.
  - Issue a write with RST=1 → the RAM word is unchanged.
